// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch buffer between program ROM and CPU front end
//
// Fetches words from a combinational-read program ROM at an internal fetch PC
// and queues {pc, word} pairs in a DEPTH-entry FIFO. The decode stage takes
// words from the FIFO head with a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetching at a new PC.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   fetch_en     in   allow new fetches (FIFO keeps draining when low)
//   rom_address  out  ROM word address (the fetch PC register)
//   rom_data     in   ROM word for rom_address, same cycle
//   redirect     in   flush FIFO and restart at redirect_pc
//   redirect_pc  in   new fetch PC
//   instr_valid  out  FIFO head valid
//   instr_data   out  FIFO head word
//   instr_pc     out  address of FIFO head word
//   instr_ready  in   consumer accepts head when instr_valid is high
//   perf_fetch   out  saturating push counter   (PREFETCH_PERF_EN only)
//   perf_flush   out  saturating redirect counter (PREFETCH_PERF_EN only)
//
// Build option: define PREFETCH_PERF_EN to add the performance counters.

module instr_prefetch #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef PREFETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetch,
    output logic [15:0]       perf_flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_WAIT
    } fetch_state_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    fetch_state_t fetch_state;
    logic         push;
    logic         pop;

    assign rom_address = fetch_pc;
    assign instr_valid = (count != '0);
    // Head comes from registered storage, so rom_data never reaches instr_data
    // combinationally.
    assign instr_data  = mem_data[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    // Fetch control. A full FIFO that is being popped this cycle still counts
    // as RUN so the slot freed by the pop is refilled without a bubble.
    always_comb begin
        fetch_state = ST_STOP;
        pop         = instr_valid & instr_ready;
        if (!fetch_en) begin
            fetch_state = ST_STOP;
        end else if ((count == FULL_COUNT) && !pop) begin
            fetch_state = ST_WAIT;
        end else begin
            fetch_state = ST_RUN;
        end
        push = (fetch_state == ST_RUN) & ~redirect;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (redirect) begin
            // Any pop in this cycle is taken by the consumer; the rest is dropped.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]   <= fetch_pc;
                mem_data[wr_ptr] <= rom_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                fetch_pc         <= fetch_pc + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (push && (perf_fetch != 16'hFFFF)) begin
                perf_fetch <= perf_fetch + 16'd1;
            end
            if (redirect && (perf_flush != 16'hFFFF)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule
